// File: rtl/spi_mem_loader.sv
// Serial loader / readback port between the external master and the processor memories.
// Frames are sampled on the system clock: cmd bit, address MSB first, then write data.
module spi_mem_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int NUM_CH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        cs_n,
    input  logic                     mosi,
    output logic                     miso,
    input  logic                     lock,
    input  logic                     err_clr,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [NUM_CH-1:0]        mem_we,
    output logic [NUM_CH-1:0]        mem_re,
    input  logic [NUM_CH*DATA_W-1:0] mem_rdata,
    output logic                     busy,
    output logic                     frame_err
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam int AW1     = ADDR_W - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_WDATA,
        ST_RWAIT,
        ST_ROUT,
        ST_IGNORE
    } state_t;

    state_t            state_q;
    logic [NUM_CH-1:0] sel_q;
    logic              cmd_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [AW1-1:0]    addr_sh_q;
    logic [DATA_W-1:0] wd_sh_q;
    logic [DATA_W-1:0] tx_q;
    logic              miso_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [NUM_CH-1:0] mem_we_q;
    logic [NUM_CH-1:0] mem_re_q;
    logic              frame_err_q;

    logic [NUM_CH-1:0] sel;
    logic              all_high;
    logic              one_low;
    logic              sel_changed;
    logic [CNT_W-1:0]  bit_cnt_d;
    logic [DATA_W-1:0] rdata_sel;

    assign sel         = ~cs_n;
    assign all_high    = &cs_n;
    assign one_low     = (sel != '0) && ((sel & (sel - NUM_CH'(1))) == '0);
    assign sel_changed = (sel != sel_q);
    // Saturate one past a full frame so an overlong write can never alias to a valid length.
    assign bit_cnt_d   = (bit_cnt_q == CNT_W'(FRAME_W + 1)) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);

    always_comb begin
        rdata_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_q[k]) rdata_sel = mem_rdata[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            cmd_q       <= 1'b0;
            bit_cnt_q   <= '0;
            addr_sh_q   <= '0;
            wd_sh_q     <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= '0;
            mem_re_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            mem_we_q <= '0;
            mem_re_q <= '0;
            // NOTE: a later non-blocking assignment in this block overrides this clear,
            // which is how an error set beats a coincident err_clr.
            if (err_clr) frame_err_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    miso_q <= 1'b0;
                    if (!all_high) begin
                        if (one_low && !lock) begin
                            state_q   <= ST_HDR;
                            sel_q     <= sel;
                            cmd_q     <= mosi;
                            bit_cnt_q <= CNT_W'(1);
                        end else begin
                            state_q     <= ST_IGNORE;
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                ST_HDR: begin
                    if (all_high) begin
                        state_q     <= ST_IDLE;
                        frame_err_q <= 1'b1;
                    end else if (sel_changed) begin
                        state_q     <= ST_IGNORE;
                        frame_err_q <= 1'b1;
                    end else begin
                        addr_sh_q <= AW1'({addr_sh_q, mosi});
                        bit_cnt_q <= bit_cnt_d;
                        if (bit_cnt_q == CNT_W'(ADDR_W)) begin
                            mem_addr_q <= {addr_sh_q, mosi};
                            if (cmd_q) begin
                                state_q <= ST_WDATA;
                            end else begin
                                state_q  <= ST_RWAIT;
                                mem_re_q <= sel_q;
                            end
                        end
                    end
                end
                ST_WDATA: begin
                    if (all_high) begin
                        state_q <= ST_IDLE;
                        if (bit_cnt_q == CNT_W'(FRAME_W)) begin
                            mem_we_q    <= sel_q;
                            mem_wdata_q <= wd_sh_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else if (sel_changed) begin
                        state_q     <= ST_IGNORE;
                        frame_err_q <= 1'b1;
                    end else begin
                        wd_sh_q   <= {wd_sh_q[DATA_W-2:0], mosi};
                        bit_cnt_q <= bit_cnt_d;
                    end
                end
                ST_RWAIT: begin
                    if (all_high) begin
                        state_q <= ST_IDLE;
                    end else if (sel_changed) begin
                        state_q     <= ST_IGNORE;
                        frame_err_q <= 1'b1;
                    end else begin
                        state_q <= ST_ROUT;
                        miso_q  <= rdata_sel[DATA_W-1];
                        tx_q    <= rdata_sel << 1;
                    end
                end
                ST_ROUT: begin
                    if (all_high) begin
                        state_q <= ST_IDLE;
                        miso_q  <= 1'b0;
                    end else if (sel_changed) begin
                        state_q     <= ST_IGNORE;
                        miso_q      <= 1'b0;
                        frame_err_q <= 1'b1;
                    end else begin
                        // Zeros shift in behind the data, so miso idles low once the word is out.
                        miso_q <= tx_q[DATA_W-1];
                        tx_q   <= tx_q << 1;
                    end
                end
                ST_IGNORE: begin
                    if (all_high) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign miso      = miso_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_mem_loader.sv
// Directed bench for spi_mem_loader: a write-frame vector table plus hand sequences
// for reset, readback timing, lock and chip-select corner cases.
module tb_spi_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cs_n;
    logic        mosi;
    logic        miso;
    logic        lock;
    logic        err_clr;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [1:0]  mem_we;
    logic [1:0]  mem_re;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        frame_err;

    int tests = 0;
    int fails = 0;
    int we_cycles = 0;

    typedef struct {
        logic [1:0]  cs;
        logic        lk;
        int          n;
        logic [15:0] val;
        logic [1:0]  we;
        logic [3:0]  addr;
        logic [7:0]  wdata;
        logic        err;
    } vec_t;

    vec_t vecs [9];

    spi_mem_loader #(.DATA_W(8), .ADDR_W(4), .NUM_CH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .lock      (lock),
        .err_clr   (err_clr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we != 2'b00) we_cycles++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends n bits of val MSB first; lock is raised from bit index lock_from onward.
    task automatic send_bits(input logic [1:0] pat, input logic [15:0] val, input int n,
                             input int lock_from);
        for (int i = n - 1; i >= 0; i--) begin
            cs_n = pat;
            mosi = val[i];
            lock = ((n - 1 - i) >= lock_from);
            tick();
        end
        cs_n = 2'b11;
        mosi = 1'b0;
        lock = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"},  32'(busy),      32'h0);
        check({tag, ".err"},   32'(frame_err), 32'h0);
        check({tag, ".we"},    32'(mem_we),    32'h0);
        check({tag, ".re"},    32'(mem_re),    32'h0);
        check({tag, ".miso"},  32'(miso),      32'h0);
        check({tag, ".addr"},  32'(mem_addr),  32'h0);
        check({tag, ".wdata"}, 32'(mem_wdata), 32'h0);
    endtask

    initial begin
        logic [7:0] exp_byte;
        logic [4:0] hdr;

        //            cs     lk    n   val       we     addr  wdata  err
        vecs[0] = '{2'b10, 1'b0, 13, 16'h13A5, 2'b01, 4'h3, 8'hA5, 1'b0};
        vecs[1] = '{2'b01, 1'b0, 13, 16'h1F0F, 2'b10, 4'hF, 8'h0F, 1'b0};
        vecs[2] = '{2'b10, 1'b0, 12, 16'h0AE6, 2'b00, 4'h5, 8'h0F, 1'b1};
        vecs[3] = '{2'b10, 1'b0, 14, 16'h2D55, 2'b00, 4'h6, 8'h0F, 1'b1};
        vecs[4] = '{2'b10, 1'b1, 13, 16'h1777, 2'b00, 4'h6, 8'h0F, 1'b1};
        vecs[5] = '{2'b00, 1'b0, 13, 16'h1888, 2'b00, 4'h6, 8'h0F, 1'b1};
        vecs[6] = '{2'b01, 1'b0,  3, 16'h0005, 2'b00, 4'h6, 8'h0F, 1'b1};
        vecs[7] = '{2'b01, 1'b0, 13, 16'h10FF, 2'b10, 4'h0, 8'hFF, 1'b0};
        vecs[8] = '{2'b10, 1'b0, 13, 16'h1A5A, 2'b01, 4'hA, 8'h5A, 1'b0};

        rst       = 1'b1;
        cs_n      = 2'b11;
        mosi      = 1'b0;
        lock      = 1'b0;
        err_clr   = 1'b0;
        mem_rdata = {8'h3C, 8'hC3};
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Write-frame table: valid writes, bad lengths, lock, multi-select, short header.
        for (int v = 0; v < 9; v++) begin
            err_clr = 1'b1;
            tick();
            err_clr   = 1'b0;
            we_cycles = 0;
            send_bits(vecs[v].cs, vecs[v].val, vecs[v].n, vecs[v].lk ? 0 : 999);
            tick();
            check($sformatf("v%0d.we_pulse", v), 32'(mem_we), 32'(vecs[v].we));
            tick();
            check($sformatf("v%0d.we_cycles", v), 32'(we_cycles), (vecs[v].we != 2'b00) ? 32'd1 : 32'd0);
            check($sformatf("v%0d.addr", v),  32'(mem_addr),  32'(vecs[v].addr));
            check($sformatf("v%0d.wdata", v), 32'(mem_wdata), 32'(vecs[v].wdata));
            check($sformatf("v%0d.err", v),   32'(frame_err), 32'(vecs[v].err));
            check($sformatf("v%0d.busy", v),  32'(busy),      32'h0);
        end

        // Asynchronous reset between edges in the middle of a write.
        we_cycles = 0;
        for (int c = 0; c < 6; c++) begin
            cs_n = 2'b10;
            mosi = c[0] ^ 1'b1;
            tick();
        end
        check("t1.busy_before", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1 check_all_zero("t1");
        cs_n = 2'b11;
        tick();
        #3 rst = 1'b0;
        tick();
        tick();
        tick();
        check("t1.we_after", 32'(we_cycles), 32'd0);
        check("t1.err_after", 32'(frame_err), 32'h0);
        check("t1.busy_after", 32'(busy), 32'h0);

        // Read from ch1: header 0,0101 then dummy ones; check strobe and miso per cycle.
        hdr      = 5'b00101;
        exp_byte = 8'h3C;
        for (int c = 0; c < 14; c++) begin
            cs_n = 2'b01;
            mosi = (c < 5) ? hdr[4-c] : 1'b1;
            tick();
            check($sformatf("t3.re_c%0d", c + 1), 32'(mem_re), (c == 4) ? 32'h2 : 32'h0);
            check($sformatf("t3.miso_c%0d", c + 1), 32'(miso),
                  (c >= 5 && c <= 12) ? 32'(exp_byte[12-c]) : 32'h0);
        end
        check("t3.addr", 32'(mem_addr), 32'h5);
        cs_n = 2'b11;
        tick();
        check("t3.busy", 32'(busy), 32'h0);
        check("t3.err", 32'(frame_err), 32'h0);

        // Truncated read from ch0 (rdata 8'hC3): release after three data bits, no error.
        hdr = 5'b00010;
        for (int c = 0; c < 8; c++) begin
            cs_n = 2'b10;
            mosi = (c < 5) ? hdr[4-c] : 1'b0;
            tick();
        end
        check("trunc.miso", 32'(miso), 32'h0);
        cs_n = 2'b11;
        tick();
        check("trunc.busy", 32'(busy), 32'h0);
        check("trunc.err", 32'(frame_err), 32'h0);
        check("trunc.addr", 32'(mem_addr), 32'h2);

        // Lock rising at cycle 6 of a valid write must not disturb it.
        we_cycles = 0;
        send_bits(2'b10, 16'h1C33, 13, 6);
        tick();
        check("t5.we_pulse", 32'(mem_we), 32'h1);
        tick();
        check("t5.we_cycles", 32'(we_cycles), 32'd1);
        check("t5.addr", 32'(mem_addr), 32'hC);
        check("t5.wdata", 32'(mem_wdata), 32'h33);
        check("t5.err", 32'(frame_err), 32'h0);

        // ch1 drops mid ch0 frame with err_clr coincident: set wins, no strobe.
        we_cycles = 0;
        for (int c = 0; c < 7; c++) begin
            cs_n = 2'b10;
            mosi = c[0];
            tick();
        end
        cs_n    = 2'b00;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t6.err_set_wins", 32'(frame_err), 32'h1);
        check("t6.busy_ignore", 32'(busy), 32'h1);
        tick();
        tick();
        cs_n = 2'b11;
        tick();
        tick();
        check("t6.we_cycles", 32'(we_cycles), 32'd0);
        check("t6.err_sticky", 32'(frame_err), 32'h1);
        check("t6.busy", 32'(busy), 32'h0);
        check("t6.wdata_hold", 32'(mem_wdata), 32'h33);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t6.err_cleared", 32'(frame_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
